// File: rtl/dac_pkg.sv
// Shared encodings, widths and header helper for the DAC frame scheduler.
package dac_pkg;

  localparam int CMD_W    = 4;
  localparam int TAG_W    = 2;
  localparam int CH_W     = 2;
  localparam int HDR_W    = CMD_W + TAG_W + CH_W;
  localparam int SAMPLE_W = 16;
  localparam int FRAME_W  = HDR_W + SAMPLE_W;

  localparam logic [CMD_W-1:0] CMD_WRITE = 4'b0001;
  localparam logic [TAG_W-1:0] HDR_TAG   = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARB       = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } dac_state_e;

  // Header layout, MSB first: command nibble, fixed tag, channel index.
  function automatic logic [HDR_W-1:0] make_header(input logic [CMD_W-1:0] cmd,
                                                   input logic [CH_W-1:0]  ch);
    return {cmd, HDR_TAG, ch};
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: the search starts one past the last grant.
module rr_arbiter4
  import dac_pkg::*;
(
  input  logic [3:0]      req,
  input  logic [CH_W-1:0] last_ch,
  output logic [3:0]      grant,
  output logic [CH_W-1:0] grant_idx,
  output logic            any
);

  logic [CH_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    // The 2-bit add wraps naturally, giving last_ch+1 .. last_ch+4 mod 4.
    for (int i = 1; i <= 4; i++) begin
      cand = last_ch + CH_W'(i);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_frame_scheduler.sv
// DAC frame scheduler: grants channels round-robin, builds a header+sample
// frame, hands it to the serializer and then waits out a programmable gap.
module dac_frame_scheduler
  import dac_pkg::*;
#(
  parameter int               N_CH      = 4,
  parameter logic [CMD_W-1:0] CMD_WRITE = dac_pkg::CMD_WRITE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH*SAMPLE_W-1:0] ch_data,
  input  logic [15:0]              frame_gap,
  output logic [N_CH-1:0]          ack,
  output logic                     ser_start,
  output logic [FRAME_W-1:0]       ser_frame,
  input  logic                     ser_ready,
  input  logic                     ser_done,
  output logic                     busy,
  output logic [CH_W-1:0]          last_ch,
  output logic [15:0]              frame_cnt,
  output logic [2:0]               state_dbg
);

  // Serializer handshake: a frame transfers in the cycle where ser_start and
  // ser_ready are both high; ser_frame is held constant until that cycle.

  dac_state_e         state_q, state_d;
  logic [FRAME_W-1:0] ser_frame_q, ser_frame_d;
  logic [CH_W-1:0]    last_ch_q, last_ch_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic [15:0]        gap_cnt_q, gap_cnt_d;

  logic [3:0]          arb_grant;
  logic [CH_W-1:0]     arb_idx;
  logic                arb_any;
  logic [SAMPLE_W-1:0] arb_sample;

  rr_arbiter4 u_arb (
    .req       (req),
    .last_ch   (last_ch_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  assign arb_sample = ch_data[{arb_idx, 4'b0000} +: SAMPLE_W];

  always_comb begin
    state_d     = state_q;
    ser_frame_d = ser_frame_q;
    last_ch_d   = last_ch_q;
    frame_cnt_d = frame_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    ack         = '0;
    ser_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && (req != '0)) state_d = ST_ARB;
      end
      ST_ARB: begin
        // A requester may have withdrawn since IDLE; with nobody left, no ack.
        if (arb_any) begin
          ack         = arb_grant;
          ser_frame_d = {make_header(CMD_WRITE, arb_idx), arb_sample};
          last_ch_d   = arb_idx;
          state_d     = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        ser_start = 1'b1;
        if (ser_ready) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (ser_done) begin
          gap_cnt_d = frame_gap;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        // Gap of 0 or 1 both take a single cycle here.
        if (gap_cnt_q <= 16'd1) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ser_frame_q <= '0;
      last_ch_q   <= 2'd3;
      frame_cnt_q <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ser_frame_q <= ser_frame_d;
      last_ch_q   <= last_ch_d;
      frame_cnt_q <= frame_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign ser_frame = ser_frame_q;
  assign last_ch   = last_ch_q;
  assign frame_cnt = frame_cnt_q;
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Self-checking bench for dac_frame_scheduler: vector table, directed corner
// sequences and a randomized run checked against a transaction-level model.
module tb_dac_frame_scheduler;
  import dac_pkg::*;

  logic        clk, reset, enable, ser_start, ser_ready, ser_done, busy;
  logic [3:0]  req, ack;
  logic [63:0] ch_data;
  logic [15:0] frame_gap, frame_cnt;
  logic [23:0] ser_frame;
  logic [1:0]  last_ch;
  logic [2:0]  state_dbg;

  dac_frame_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .ch_data(ch_data),
    .frame_gap(frame_gap), .ack(ack), .ser_start(ser_start), .ser_frame(ser_frame),
    .ser_ready(ser_ready), .ser_done(ser_done), .busy(busy), .last_ch(last_ch),
    .frame_cnt(frame_cnt), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  // ---------------- scoreboard / model state ----------------
  int          n_checks = 0, n_fail = 0;
  logic [23:0] exp_q[$];
  logic [1:0]  grant_log[$];
  int          m_last = 3;
  logic [15:0] m_cnt = '0;
  bit          waiting_done = 0, in_gap = 0, rand_mode = 0, prev_en = 0;
  int          gap_seen = 0, exp_gap = 0, done_delay = 0, ser_lat = 1;
  int          gaps_done = 0, n_grants = 0, drop_mode = 0;
  logic [3:0]  pending_ack = '0;
  logic [1:0]  act_ch = '0;
  logic [23:0] act_frame = '0;
  int          act_gap = 0;

  typedef struct {
    logic [3:0]  req;
    logic [63:0] data;
    logic [15:0] gap;
    logic [1:0]  exp_ch;
    logic [23:0] exp_frame;
    int          exp_gap;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round robin rule: first requester strictly after the previous grant.
  function automatic int rr_pick(input int last, input logic [3:0] r);
    int pick = -1;
    for (int i = 1; i <= 4; i++)
      if (pick < 0 && r[(last + i) % 4]) pick = (last + i) % 4;
    return pick;
  endfunction

  function automatic logic [23:0] ref_frame(input int ch, input logic [63:0] d);
    logic [15:0] s;
    s = d[16*ch +: 16];
    return {4'b0001, 2'b01, 2'(ch), s};
  endfunction

  // Monitor + model, runs on the falling edge.
  task automatic sample();
    int          e;
    logic [23:0] f;
    if (in_gap) begin
      if (busy) gap_seen++;
      else begin
        check("gap_len", 64'(gap_seen), 64'(exp_gap));
        act_gap = gap_seen;
        in_gap = 0;
        gaps_done++;
      end
    end
    if (ser_done && waiting_done) begin
      waiting_done = 0;
      in_gap = 1;
      gap_seen = 0;
      exp_gap = (frame_gap == 16'd0) ? 1 : int'(frame_gap);
    end
    if (ack != 4'b0) begin
      e = rr_pick(m_last, req);
      if (e < 0) check("ack_without_req", 64'(ack), 64'd0);
      else begin
        check("ack_grant", 64'(ack), 64'(4'b0001 << e));
        check("ack_enable", 64'(prev_en), 64'd1);
        m_last = e;
        exp_q.push_back(ref_frame(e, ch_data));
      end
      for (int k = 0; k < 4; k++) if (ack[k]) act_ch = 2'(k);
      grant_log.push_back(act_ch);
      pending_ack = ack;
      n_grants++;
    end
    if (ser_start && ser_ready) begin
      check("hs_queued", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        f = exp_q.pop_front();
        check("ser_frame", 64'(ser_frame), 64'(f));
      end
      check("frame_cnt_hs", 64'(frame_cnt), 64'(m_cnt));
      m_cnt = m_cnt + 16'd1;
      act_frame = ser_frame;
      waiting_done = 1;
      done_delay = rand_mode ? int'($urandom_range(1, 4)) : ser_lat;
    end
    prev_en = enable;
  endtask

  // ---------------- driver ----------------
  task automatic drive();
    ser_done = 1'b0;
    if (done_delay > 0) begin
      done_delay--;
      if (done_delay == 0) ser_done = 1'b1;
    end else if (rand_mode && !waiting_done && $urandom_range(0, 9) == 0) begin
      ser_done = 1'b1;
    end
    if (pending_ack != 4'b0) begin
      if (drop_mode == 0) req = 4'b0;
      else if (drop_mode == 2) req = req & ~pending_ack;
      pending_ack = 4'b0;
    end
    if (rand_mode) begin
      ser_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) frame_gap = 16'($urandom_range(0, 6));
      for (int k = 0; k < 4; k++) begin
        if (!req[k]) begin
          if ($urandom_range(0, 5) == 0) begin
            ch_data[16*k +: 16] = 16'($urandom);
            req[k] = 1'b1;
          end
        end else if ($urandom_range(0, 40) == 0) begin
          req[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_ser_start", 64'(ser_start), 64'd0);
    check("rst_ser_frame", 64'(ser_frame), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_last_ch", 64'(last_ch), 64'd3);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    exp_q.delete();
    m_last = 3; m_cnt = '0;
    waiting_done = 0; in_gap = 0; done_delay = 0; pending_ack = '0;
    req = '0; ser_done = 1'b0; ser_lat = 1;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_frame_end(input string name, input int bound);
    int g0 = gaps_done;
    for (int t = 0; t < bound && gaps_done == g0; t++) cycle();
    check(name, 64'(gaps_done != g0), 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    req = v.req; ch_data = v.data; frame_gap = v.gap; ser_ready = 1'b1;
    wait_frame_end("vec_done", 100);
    check("vec_ch", 64'(act_ch), 64'(v.exp_ch));
    check("vec_last_ch", 64'(last_ch), 64'(v.exp_ch));
    check("vec_frame", 64'(act_frame), 64'(v.exp_frame));
    check("vec_gap", 64'(act_gap), 64'(v.exp_gap));
    check("vec_cnt", 64'(frame_cnt), 64'(idx + 1));
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[7];
  int   exp_order[5];

  initial begin
    vecs[0] = '{4'b0100, 64'h1111_D980_3333_4444, 16'd0, 2'd2, 24'h16D980, 1};
    vecs[1] = '{4'b1111, 64'hA003_A002_A001_A000, 16'd5, 2'd3, 24'h17A003, 5};
    vecs[2] = '{4'b1111, 64'hA003_A002_A001_A000, 16'd1, 2'd0, 24'h14A000, 1};
    vecs[3] = '{4'b0011, 64'hB3B3_B2B2_B1B1_B0B0, 16'd3, 2'd1, 24'h15B1B1, 3};
    vecs[4] = '{4'b0011, 64'hB3B3_B2B2_B1B1_B0B0, 16'd2, 2'd0, 24'h14B0B0, 2};
    vecs[5] = '{4'b1000, 64'hFFFF_0000_1234_5678, 16'd0, 2'd3, 24'h17FFFF, 1};
    vecs[6] = '{4'b1001, 64'hFFFF_0000_1234_5678, 16'd7, 2'd0, 24'h145678, 7};
    exp_order = '{0, 1, 2, 3, 0};

    reset = 1'b1; enable = 1'b0; req = '0; ch_data = '0; frame_gap = '0;
    ser_ready = 1'b0; ser_done = 1'b0;
    #2;
    apply_reset();
    enable = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Serializer stalls for 10 cycles while the frame is offered.
    req = 4'b0010; ch_data = 64'h0000_0000_C0DE_0000; frame_gap = '0; ser_ready = 1'b0;
    for (int t = 0; t < 20 && !ser_start; t++) cycle();
    check("stall_reach", 64'(ser_start), 64'd1);
    for (int t = 0; t < 10; t++) begin
      cycle();
      check("stall_start", 64'(ser_start), 64'd1);
      check("stall_frame", 64'(ser_frame), 64'h15C0DE);
      check("stall_cnt", 64'(frame_cnt), 64'd7);
    end
    ser_ready = 1'b1;
    wait_frame_end("stall_done", 50);
    check("stall_cnt_after", 64'(frame_cnt), 64'd8);

    // All channels requesting continuously: strict rotation from channel 0.
    apply_reset();
    drop_mode = 1; req = 4'b1111; ch_data = 64'h4444_3333_2222_1111; ser_ready = 1'b1;
    grant_log.delete();
    for (int t = 0; t < 100 && grant_log.size() < 5; t++) cycle();
    check("rr_grants", 64'(grant_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      check("rr_order", 64'(grant_log[i]), 64'(exp_order[i]));
    req = '0; drop_mode = 0;
    for (int t = 0; t < 50 && busy; t++) cycle();
    check("rr_idle", 64'(busy), 64'd0);
    check("rr_cnt", 64'(frame_cnt), 64'd5);

    // Reset while waiting for ser_done, then reset while offering a frame.
    ser_lat = 50; req = 4'b0100;
    for (int t = 0; t < 20 && !waiting_done; t++) cycle();
    check("wd_reach", 64'(waiting_done), 64'd1);
    cycle(); cycle();
    check("wd_state", 64'(state_dbg), 64'(ST_WAIT_DONE));
    apply_reset();
    ser_ready = 1'b0; req = 4'b0001;
    for (int t = 0; t < 20 && !ser_start; t++) cycle();
    check("issue_reach", 64'(ser_start), 64'd1);
    apply_reset();

    // Counter wrap: preload to all-ones, one more accepted frame wraps it.
    ser_ready = 1'b1;
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    m_cnt = 16'hFFFF;
    @(posedge clk);
    #1;
    check("wrap_pre", 64'(frame_cnt), 64'hFFFF);
    req = 4'b0001; ch_data = 64'h0000_0000_0000_BEEF;
    wait_frame_end("wrap_done", 50);
    check("wrap_cnt", 64'(frame_cnt), 64'h0000);
    check("wrap_frame", 64'(act_frame), 64'h14BEEF);

    // Randomized traffic against the model, then drain.
    rand_mode = 1; drop_mode = 2;
    for (int t = 0; t < 4000; t++) cycle();
    rand_mode = 0; enable = 1'b1; ser_ready = 1'b1;
    for (int t = 0; t < 400 && (req != 4'b0 || busy || waiting_done || in_gap || done_delay != 0); t++)
      cycle();
    check("drain_idle", 64'(req == 4'b0 && !busy), 64'd1);
    check("drain_queue", 64'(exp_q.size()), 64'd0);
    check("drain_cnt", 64'(frame_cnt), 64'(m_cnt));
    check("rand_grants", 64'(n_grants > 50), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
